// File: rtl/dp_executor.sv
// Purpose : executes one datapath instruction (NOP, DRAW, LOAD, STORE) per start/finish handshake.
// Latency : NOP/illegal done at N+1, DRAW/STORE at N+2, LOAD at N+MEM_LATENCY+2 (N = acceptance cycle).
// Backpressure: start_dp is only sampled in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clock, resetn        : rising-edge clock, asynchronous active-low reset
//   start_dp             : instruction valid, sampled only when idle
//   instruction_dp       : [31:28] opcode, remaining bits are opcode-specific fields
//   finished_dp          : one-cycle completion pulse (DONE state)
//   illegal_op           : one-cycle pulse alongside finished_dp for opcodes 4..15
//   busy                 : high from the cycle after acceptance through DONE
//   result_dp            : data of the most recent completed LOAD
//   mem_address/mem_wren/mem_data/mem_q : single-port game-state RAM
//   vga_x/vga_y/vga_colour/vga_plot     : VGA adapter pixel port
module dp_executor #(
    parameter int MEM_ADDR_WIDTH    = 16,
    parameter int RESULT_WIDTH      = 16,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int MEM_LATENCY       = 2
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start_dp,
    input  logic [INSTRUCTION_WIDTH-1:0]  instruction_dp,
    output logic                          finished_dp,
    output logic [RESULT_WIDTH-1:0]       result_dp,
    output logic                          busy,
    output logic                          illegal_op,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_address,
    output logic                          mem_wren,
    output logic [RESULT_WIDTH-1:0]       mem_data,
    input  logic [RESULT_WIDTH-1:0]       mem_q,
    output logic [7:0]                    vga_x,
    output logic [6:0]                    vga_y,
    output logic [2:0]                    vga_colour,
    output logic                          vga_plot
);

    localparam logic [3:0] OP_DRAW  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;

    // Last LOAD_WAIT count: LOAD_WAIT spans MEM_LATENCY cycles so that the
    // RAM word launched in LOAD_ADDR is sampled in the final one.
    localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_STORE,
        S_LOAD_ADDR,
        S_LOAD_WAIT,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [2:0]                r_cnt;
    logic                      r_finished;
    logic                      r_illegal;
    logic                      r_busy;
    logic [RESULT_WIDTH-1:0]   r_result;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_address;
    logic                      r_mem_wren;
    logic [RESULT_WIDTH-1:0]   r_mem_data;
    logic [7:0]                r_vga_x;
    logic [6:0]                r_vga_y;
    logic [2:0]                r_vga_colour;
    logic                      r_vga_plot;

    logic [3:0]                w_opcode;
    logic                      w_accept;
    logic                      w_wait_last;

    assign w_opcode    = instruction_dp[31:28];
    assign w_accept    = (r_state == S_IDLE) && start_dp;
    assign w_wait_last = (r_cnt == LAT_LAST);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_dp) begin
                    case (w_opcode)
                        OP_DRAW:  w_next_state = S_DRAW;
                        OP_LOAD:  w_next_state = S_LOAD_ADDR;
                        OP_STORE: w_next_state = S_STORE;
                        default:  w_next_state = S_DONE;   // NOP and illegal opcodes
                    endcase
                end
            end
            S_DRAW:      w_next_state = S_DONE;
            S_STORE:     w_next_state = S_DONE;
            S_LOAD_ADDR: w_next_state = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (w_wait_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Output registers. Everything is loaded one edge ahead from the next
    // state / accepted instruction so that outputs line up with the state
    // they belong to without any combinational input-to-output path.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt         <= '0;
            r_finished    <= 1'b0;
            r_illegal     <= 1'b0;
            r_busy        <= 1'b0;
            r_result      <= '0;
            r_mem_address <= '0;
            r_mem_wren    <= 1'b0;
            r_mem_data    <= '0;
            r_vga_x       <= '0;
            r_vga_y       <= '0;
            r_vga_colour  <= '0;
            r_vga_plot    <= 1'b0;
        end else begin
            r_busy     <= (w_next_state != S_IDLE);
            r_finished <= (w_next_state == S_DONE);
            // Only NOP/illegal go straight from IDLE to DONE, so the flag
            // lands exactly on the DONE cycle of an illegal instruction.
            r_illegal  <= w_accept && (w_opcode > OP_STORE);
            r_mem_wren <= w_accept && (w_opcode == OP_STORE);
            r_vga_plot <= w_accept && (w_opcode == OP_DRAW) && instruction_dp[18];

            if (w_accept && (w_opcode == OP_DRAW)) begin
                r_vga_x      <= instruction_dp[7:0];
                r_vga_y      <= instruction_dp[14:8];
                r_vga_colour <= instruction_dp[17:15];
            end

            if (w_accept && ((w_opcode == OP_LOAD) || (w_opcode == OP_STORE))) begin
                r_mem_address <= instruction_dp[MEM_ADDR_WIDTH-1:0];
            end

            if (w_accept && (w_opcode == OP_STORE)) begin
                r_mem_data <= RESULT_WIDTH'(instruction_dp[27:16]);
            end

            // Counter is zero on entry to LOAD_WAIT because it is cleared in
            // every other state, including LOAD_ADDR.
            if (r_state == S_LOAD_WAIT) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= '0;
            end

            if ((r_state == S_LOAD_WAIT) && w_wait_last) begin
                r_result <= mem_q;
            end
        end
    end

    assign finished_dp = r_finished;
    assign illegal_op  = r_illegal;
    assign busy        = r_busy;
    assign result_dp   = r_result;
    assign mem_address = r_mem_address;
    assign mem_wren    = r_mem_wren;
    assign mem_data    = r_mem_data;
    assign vga_x       = r_vga_x;
    assign vga_y       = r_vga_y;
    assign vga_colour  = r_vga_colour;
    assign vga_plot    = r_vga_plot;

endmodule

// File: tb/tb_dp_executor.sv
// Purpose : self-checking bench for dp_executor with a latency-2 RAM model and a scoreboard.
// Latency : expected completion times come from the instruction-level timing rules.
// Backpressure: start_dp is sometimes held high across busy periods to exercise drop/re-issue.
module tb_dp_executor;

    localparam int LAT = 2;   // the RAM model below implements exactly two cycles

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start_dp = 1'b0;
    logic [31:0] instruction_dp = '0;
    logic        finished_dp;
    logic [15:0] result_dp;
    logic        busy;
    logic        illegal_op;
    logic [15:0] mem_address;
    logic        mem_wren;
    logic [15:0] mem_data;
    logic [15:0] mem_q;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    dp_executor #(
        .MEM_ADDR_WIDTH(16), .RESULT_WIDTH(16), .INSTRUCTION_WIDTH(32), .MEM_LATENCY(LAT)
    ) dut (
        .clock(clock), .resetn(resetn), .start_dp(start_dp), .instruction_dp(instruction_dp),
        .finished_dp(finished_dp), .result_dp(result_dp), .busy(busy), .illegal_op(illegal_op),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    // Cycle index: during the cycle following the k-th rising edge, cyc == k.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- RAM environment (two-cycle read latency) ----------------
    logic [15:0] ram     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ap0 = '0;
    logic [15:0] ap1 = '0;
    always @(posedge clock) begin
        ap0 <= mem_address;
        ap1 <= ap0;
        if (mem_wren) ram[mem_address] <= mem_data;
    end
    assign mem_q = ram[ap1];

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endfunction

    typedef struct {
        int          acc;
        int          fin;
        logic [31:0] ins;
        logic [15:0] res;
    } exp_t;
    exp_t sbq[$];

    // Reference view of the held outputs.
    logic [15:0] exp_addr = '0, exp_data = '0, exp_result = '0;
    logic [7:0]  exp_x = '0;
    logic [6:0]  exp_y = '0;
    logic [2:0]  exp_col = '0;

    bit          mon_en = 1'b0;
    exp_t        m_e;
    logic [3:0]  m_op;
    logic        m_busy, m_fin, m_ill, m_wren, m_plot;

    always @(negedge clock) begin
        if (mon_en) begin
            m_busy = 1'b0; m_fin = 1'b0; m_ill = 1'b0; m_wren = 1'b0; m_plot = 1'b0;
            if (sbq.size() > 0) begin
                m_e  = sbq[0];
                m_op = m_e.ins[31:28];
                if (cyc == m_e.acc + 1) begin
                    case (m_op)
                        4'd1: begin
                            exp_x   = m_e.ins[7:0];
                            exp_y   = m_e.ins[14:8];
                            exp_col = m_e.ins[17:15];
                            m_plot  = m_e.ins[18];
                        end
                        4'd2: exp_addr = m_e.ins[15:0];
                        4'd3: begin
                            exp_addr = m_e.ins[15:0];
                            exp_data = {4'h0, m_e.ins[27:16]};
                            m_wren   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                m_busy = (cyc > m_e.acc) && (cyc <= m_e.fin);
                if (cyc == m_e.fin) begin
                    m_fin = 1'b1;
                    m_ill = (m_op > 4'd3);
                    if (m_op == 4'd2) exp_result = m_e.res;
                end
            end
            chk("finished_dp", 32'(finished_dp), 32'(m_fin));
            chk("illegal_op",  32'(illegal_op),  32'(m_ill));
            chk("busy",        32'(busy),        32'(m_busy));
            chk("mem_wren",    32'(mem_wren),    32'(m_wren));
            chk("vga_plot",    32'(vga_plot),    32'(m_plot));
            chk("mem_address", 32'(mem_address), 32'(exp_addr));
            chk("mem_data",    32'(mem_data),    32'(exp_data));
            chk("vga_x",       32'(vga_x),       32'(exp_x));
            chk("vga_y",       32'(vga_y),       32'(exp_y));
            chk("vga_colour",  32'(vga_colour),  32'(exp_col));
            chk("result_dp",   32'(result_dp),   32'(exp_result));
            if (sbq.size() > 0 && cyc >= sbq[0].fin) sbq.delete(0);
        end
    end

    // ---------------- stimulus ----------------
    int free = 0;   // first cycle the executor is expected to be idle

    task automatic chk_all_zero(input string tag);
        chk({tag, " finished_dp"}, 32'(finished_dp), 0);
        chk({tag, " illegal_op"},  32'(illegal_op),  0);
        chk({tag, " busy"},        32'(busy),        0);
        chk({tag, " mem_wren"},    32'(mem_wren),    0);
        chk({tag, " vga_plot"},    32'(vga_plot),    0);
        chk({tag, " mem_address"}, 32'(mem_address), 0);
        chk({tag, " mem_data"},    32'(mem_data),    0);
        chk({tag, " vga_x"},       32'(vga_x),       0);
        chk({tag, " vga_y"},       32'(vga_y),       0);
        chk({tag, " vga_colour"},  32'(vga_colour),  0);
        chk({tag, " result_dp"},   32'(result_dp),   0);
    endtask

    // Called at a falling edge. Holds start_dp high until the instruction is
    // expected to be taken, records the expectation, then optionally idles.
    task automatic issue(input logic [31:0] ins, input int gap);
        exp_t        e;
        logic [3:0]  op;
        logic [15:0] a;
        int          lat;
        start_dp       = 1'b1;
        instruction_dp = ins;
        while (cyc < free) @(negedge clock);
        op = ins[31:28];
        a  = ins[15:0];
        e.acc = cyc;
        e.ins = ins;
        e.res = '0;
        if (op == 4'd3) ref_mem[a] = {4'h0, ins[27:16]};
        if (op == 4'd2) e.res = ref_mem[a];
        lat   = (op == 4'd1 || op == 4'd3) ? 2 : (op == 4'd2) ? LAT + 2 : 1;
        e.fin = e.acc + lat;
        free  = e.fin + 1;
        sbq.push_back(e);
        @(negedge clock);
        if (gap > 0) begin
            start_dp       = 1'b0;
            instruction_dp = $urandom;
            repeat (gap - 1) @(negedge clock);
        end
    endtask

    function automatic logic [31:0] rand_ins();
        logic [15:0] a;
        int          k;
        k = $urandom_range(0, 4);
        a = 16'($urandom_range(32, 95));
        case (k)
            0:       return {4'd0, 28'($urandom)};
            1:       return {4'd1, 9'd0, 19'($urandom)};
            2:       return {4'd2, 12'd0, a};
            3:       return {4'd3, 12'($urandom), a};
            default: return {4'($urandom_range(4, 15)), 28'($urandom)};
        endcase
    endfunction

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            ram[i]     = v;
            ref_mem[i] = v;
        end
        ram[5]     = 16'hBEEF;
        ref_mem[5] = 16'hBEEF;

        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        resetn = 1'b1;
        free   = cyc;
        mon_en = 1'b1;

        // Directed cases
        issue(32'h2000_0005, 1);                                // LOAD 5 -> BEEF
        issue(32'h3ABC_0010, 1);                                // STORE 0ABC @ 0x10
        issue(32'h2000_0010, 2);                                // LOAD 0x10 -> 0ABC
        issue({4'd1, 9'd0, 1'b1, 3'b010, 7'd119, 8'd159}, 1);   // DRAW with strobe
        issue({4'd1, 9'd0, 1'b0, 3'b101, 7'd3, 8'd7}, 1);       // DRAW, no strobe
        issue({4'd1, 9'd0, 1'b1, 3'b111, 7'd127, 8'd255}, 1);   // out-of-range coords
        issue(32'hF123_4567, 1);                                // illegal
        issue(32'h3055_0005, 0);                                // back-to-back, start held
        issue(32'h2000_0005, 0);
        issue(32'h0FFF_FFFF, 0);
        issue(32'h4000_0000, 2);

        // Randomized traffic
        repeat (250) issue(rand_ins(), $urandom_range(0, 3));

        // Reset in the middle of a LOAD
        start_dp = 1'b0;
        while (cyc < free) @(negedge clock);
        mon_en         = 1'b0;
        start_dp       = 1'b1;
        instruction_dp = 32'h2000_0005;       // accepted this cycle (N)
        @(negedge clock);                      // N+1
        start_dp = 1'b0;
        @(negedge clock);                      // N+2
        resetn = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) begin
            @(negedge clock);
            chk("midreset no finished_dp", 32'(finished_dp), 0);
            chk("midreset busy",           32'(busy),        0);
        end
        resetn     = 1'b1;
        exp_addr   = '0; exp_data = '0; exp_result = '0;
        exp_x      = '0; exp_y = '0; exp_col = '0;
        sbq.delete();
        free       = cyc;
        mon_en     = 1'b1;
        issue(32'h2000_0005, 1);
        issue(32'h2000_0010, 1);
        repeat (20) issue(rand_ins(), $urandom_range(0, 2));

        start_dp = 1'b0;
        while (cyc <= free + 2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
